// File: rtl/pr_freelist_ctrl_pkg.sv
// Shared rename-stage sizing for the physical-register free list.
package pr_freelist_ctrl_pkg;
  localparam int N_WAY          = 2;
  localparam int XLEN           = 32;
  localparam int NUM_PR_DEFAULT = 64;
  localparam int RANK_BITS      = $clog2(N_WAY + 1);
endpackage

// File: rtl/pr_freelist_ctrl_lane_prefix_count.sv
// Per-lane count of set bits in the lower-numbered lanes, plus the total.
module lane_prefix_count #(
  parameter int LANES = 2,
  parameter int CW    = 2
) (
  input  logic [LANES-1:0]         bits,
  output logic [LANES-1:0][CW-1:0] rank,
  output logic [CW-1:0]            total
);
  logic [CW-1:0] acc;

  always_comb begin
    acc  = '0;
    rank = '0;
    for (int n = 0; n < LANES; n++) begin
      rank[n] = acc;
      acc     = acc + CW'(bits[n]);
    end
    total = acc;
  end
endmodule

// File: rtl/pr_freelist_ctrl.sv
// Free-list controller: offers unmapped physical tags to dispatch lanes in
// program order, reclaims retired tags, and rewinds to the retire head on branch_haz.
module pr_freelist_ctrl
  import pr_freelist_ctrl_pkg::*;
#(
  parameter  int NUM_PR   = NUM_PR_DEFAULT,
  localparam int CDB_BITS = $clog2(NUM_PR),
  localparam int DEPTH    = NUM_PR - XLEN - 1
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [N_WAY-1:0]                 dis_req,
  input  logic [N_WAY-1:0]                 ret_valid,
  input  logic [N_WAY-1:0][CDB_BITS-1:0]   ret_pr_old,
  input  logic                             branch_haz,
  output logic [N_WAY-1:0][CDB_BITS-1:0]   pr_freelist,
  output logic [CDB_BITS:0]                free_count,
  output logic                             empty
);
  localparam int IW = CDB_BITS - 1;

  // Pointers are {wrap, index}; the index wraps at DEPTH, not at a power of two.
  function automatic logic [CDB_BITS-1:0] ptr_add(input logic [CDB_BITS-1:0] p,
                                                  input logic [RANK_BITS-1:0] k);
    logic [IW:0]         sum;
    logic [CDB_BITS-1:0] r;
    sum = {1'b0, p[IW-1:0]} + (IW+1)'(k);
    if (sum >= (IW+1)'(DEPTH)) begin
      r[IW-1:0] = IW'(sum - (IW+1)'(DEPTH));
      r[IW]     = ~p[IW];
    end else begin
      r[IW-1:0] = sum[IW-1:0];
      r[IW]     = p[IW];
    end
    return r;
  endfunction

  function automatic logic [IW-1:0] idx_add(input logic [CDB_BITS-1:0] p,
                                            input logic [RANK_BITS-1:0] k);
    logic [CDB_BITS-1:0] r;
    r = ptr_add(p, k);
    return r[IW-1:0];
  endfunction

  function automatic logic [CDB_BITS:0] count_between(input logic [CDB_BITS-1:0] a,
                                                      input logic [CDB_BITS-1:0] b);
    logic [CDB_BITS:0] ai;
    logic [CDB_BITS:0] bi;
    ai = (CDB_BITS+1)'(a[IW-1:0]);
    bi = (CDB_BITS+1)'(b[IW-1:0]);
    if (a[IW] == b[IW]) return bi - ai;
    return (CDB_BITS+1)'(DEPTH) + bi - ai;
  endfunction

  logic [CDB_BITS-1:0]                 tag_buf [DEPTH];
  logic [CDB_BITS-1:0]                 head, tail, rhead;
  logic [CDB_BITS-1:0]                 head_next, tail_next, rhead_next;
  logic [N_WAY-1:0][RANK_BITS-1:0]     dis_rank, ret_rank;
  logic [RANK_BITS-1:0]                dis_total, ret_total, allocs;
  logic [N_WAY-1:0][IW-1:0]            offer_idx, ret_idx;
  logic [CDB_BITS+1:0]                 fc_sum;

  lane_prefix_count #(.LANES(N_WAY), .CW(RANK_BITS)) u_dis_rank (
    .bits  (dis_req),
    .rank  (dis_rank),
    .total (dis_total)
  );

  lane_prefix_count #(.LANES(N_WAY), .CW(RANK_BITS)) u_ret_rank (
    .bits  (ret_valid),
    .rank  (ret_rank),
    .total (ret_total)
  );

  always_comb begin
    free_count = count_between(head, tail);
    empty      = (free_count == '0);
  end

  always_comb begin
    pr_freelist = '0;
    offer_idx   = '0;
    for (int n = 0; n < N_WAY; n++) begin
      offer_idx[n] = idx_add(head, dis_rank[n]);
      if (!branch_haz && dis_req[n] && ((CDB_BITS+1)'(dis_rank[n]) < free_count))
        pr_freelist[n] = tag_buf[offer_idx[n]];
    end
  end

  // Grants form a prefix of the requesters, so the grant count is min(requests, free).
  always_comb begin
    if (branch_haz)
      allocs = '0;
    else if ((CDB_BITS+1)'(dis_total) < free_count)
      allocs = dis_total;
    else
      allocs = RANK_BITS'(free_count);
  end

  always_comb begin
    ret_idx = '0;
    for (int n = 0; n < N_WAY; n++)
      ret_idx[n] = idx_add(tail, ret_rank[n]);
    rhead_next = ptr_add(rhead, ret_total);
    tail_next  = ptr_add(tail, ret_total);
    head_next  = branch_haz ? rhead_next : ptr_add(head, allocs);
    fc_sum     = (CDB_BITS+2)'(free_count) + (CDB_BITS+2)'(ret_total) - (CDB_BITS+2)'(allocs);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        tag_buf[i] <= CDB_BITS'(XLEN + 1 + i);
      head  <= '0;
      rhead <= '0;
      tail  <= {1'b1, {IW{1'b0}}};
    end else begin
      for (int n = 0; n < N_WAY; n++)
        if (ret_valid[n]) tag_buf[ret_idx[n]] <= ret_pr_old[n];
      head  <= head_next;
      tail  <= tail_next;
      rhead <= rhead_next;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      for (int n = 0; n < N_WAY; n++)
        assert (!(ret_valid[n] && ret_pr_old[n] == '0));
      assert (fc_sum <= (CDB_BITS+2)'(DEPTH));
    end
  end
endmodule
